// File: rtl/ex_stage_if.sv
// ex_stage_if
//   Bundles the id_ex -> EX inputs and the EX result outputs of the execute stage.
//   master: driven by the id_ex register side (decode), reads results/stall/HI/LO.
//   slave : the execute stage itself.
// Signals
//   aluop_i   [7:0]  operation code
//   alusel_i  [2:0]  result class
//   reg1_i    [31:0] operand 1 (register, immediate or shift amount)
//   reg2_i    [31:0] operand 2
//   wd_i      [4:0]  destination register address
//   wreg_i           destination write enable from decode
//   wd_o      [4:0]  destination address passed on
//   wreg_o           destination write enable
//   wdata_o   [31:0] result, also forwarded to decode
//   stall_req_o      high while a multiply holds the upstream stages
//   hi_o      [31:0] current HI register
//   lo_o      [31:0] current LO register
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage
//   Execute stage. Logic, shift and move results are combinational so decode
//   can forward wdata_o in the same cycle. Owns HI/LO and runs MULTU (and
//   optionally MULT) as a 32-step shift-add multiplier, requesting a stall
//   while it works.
// Ports
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   ex   ex_stage_if.slave: operands/opcode in, result/stall/HI/LO out
// Configuration
//   EX_SIGNED_MUL_EN  when defined, MULT runs on |r1|*|r2| and the product is
//                     negated at the end if the operand signs differ; when
//                     undefined, MULT behaves as a NOP.
//
// Multiply FSM
//   state  | meaning
//   IDLE   | no multiply running; a multiply opcode latches operands here
//   BUSY   | one shift-add step per cycle, 32 cycles
//   DONE   | product ready; written to {HI,LO} at the edge leaving DONE
module ex_stage (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave ex
);

  localparam int MUL_STEPS = 32;
  localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
  localparam logic [7:0] OP_ORI   = 8'b0101_1010;
  localparam logic [7:0] OP_XORI  = 8'b0101_1011;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SLLV  = 8'b0000_0100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRLV  = 8'b0000_0110;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_SRAV  = 8'b0000_0111;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t  state, state_nxt;
  logic [31:0] hi, lo;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg;

  logic        is_mult;
  logic        start;
  logic [31:0] op1_abs, op2_abs;
  logic        start_neg;
  logic [63:0] mul_res;
  logic        stall_comb;
  logic [31:0] res;
  logic        res_ok;
  logic [4:0]  sh_amt;

`ifdef EX_SIGNED_MUL_EN
  assign is_mult   = (ex.aluop_i == OP_MULT);
  assign op1_abs   = (is_mult && ex.reg1_i[31]) ? (~ex.reg1_i + 32'd1) : ex.reg1_i;
  assign op2_abs   = (is_mult && ex.reg2_i[31]) ? (~ex.reg2_i + 32'd1) : ex.reg2_i;
  assign start_neg = is_mult && (ex.reg1_i[31] ^ ex.reg2_i[31]);
`else
  assign is_mult   = 1'b0;
  assign op1_abs   = ex.reg1_i;
  assign op2_abs   = ex.reg2_i;
  assign start_neg = 1'b0;
`endif

  assign start   = (state == S_IDLE) && ((ex.aluop_i == OP_MULTU) || is_mult);
  assign mul_res = neg ? (~acc + 64'd1) : acc;

  always_comb begin
    state_nxt  = state;
    stall_comb = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_BUSY;
          stall_comb = 1'b1;
        end
      end
      S_BUSY: begin
        stall_comb = 1'b1;
        if (cnt == LAST_STEP) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {32'd0, op1_abs};
            mplier <= op2_abs;
            acc    <= '0;
            cnt    <= '0;
            neg    <= start_neg;
          end
        end
        S_BUSY: begin
          // mcand is kept pre-shifted, so adding it equals adding multiplicand<<cnt
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        default: ;
      endcase
      // The multiply result wins over a move into HI/LO in the same cycle.
      if (state == S_DONE) begin
        hi <= mul_res[63:32];
        lo <= mul_res[31:0];
      end else begin
        if (ex.aluop_i == OP_MTHI) hi <= ex.reg1_i;
        if (ex.aluop_i == OP_MTLO) lo <= ex.reg1_i;
      end
    end
  end

  assign sh_amt = ex.reg1_i[4:0];

  always_comb begin
    res    = '0;
    res_ok = 1'b0;
    case (ex.alusel_i)
      RES_LOGIC: begin
        res_ok = 1'b1;
        case (ex.aluop_i)
          OP_OR, OP_ORI:   res = ex.reg1_i | ex.reg2_i;
          OP_AND, OP_ANDI: res = ex.reg1_i & ex.reg2_i;
          OP_XOR, OP_XORI: res = ex.reg1_i ^ ex.reg2_i;
          OP_NOR:          res = ~(ex.reg1_i | ex.reg2_i);
          default:         res_ok = 1'b0;
        endcase
      end
      RES_SHIFT: begin
        res_ok = 1'b1;
        case (ex.aluop_i)
          OP_SLL, OP_SLLV: res = ex.reg2_i << sh_amt;
          OP_SRL, OP_SRLV: res = ex.reg2_i >> sh_amt;
          OP_SRA, OP_SRAV: res = $unsigned($signed(ex.reg2_i) >>> sh_amt);
          default:         res_ok = 1'b0;
        endcase
      end
      RES_MOVE: begin
        res_ok = 1'b1;
        case (ex.aluop_i)
          OP_MFHI:          res = hi;
          OP_MFLO:          res = lo;
          OP_MOVN, OP_MOVZ: res = ex.reg1_i;
          default:          res_ok = 1'b0;
        endcase
      end
      RES_NOP: ;
      default: ;
    endcase
    if (!res_ok) res = '0;
  end

  always_comb begin
    if (rst) begin
      ex.wdata_o     = '0;
      ex.wd_o        = NOP_REG_ADDR;
      ex.wreg_o      = 1'b0;
      ex.stall_req_o = 1'b0;
    end else begin
      ex.wdata_o     = res;
      ex.wd_o        = ex.wd_i;
      ex.wreg_o      = ex.wreg_i && res_ok;
      ex.stall_req_o = stall_comb;
    end
  end

  assign ex.hi_o = hi;
  assign ex.lo_o = lo;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
//   Directed bench for ex_stage: single-cycle ops, HI/LO moves, multiply
//   timing and results, reset during a multiply, and MULT with or without
//   EX_SIGNED_MUL_EN.
module tb_ex_stage;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_ORI   = 8'b0101_1010;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SLLV  = 8'b0000_0100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_stall;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] wd, input logic wreg);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
  endtask

  // Issues a multiply in the current cycle, then scrambles the inputs and
  // counts stall cycles; returns in the first non-stalled cycle.
  task automatic run_mul(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
    drive(op, SEL_NOP, a, b, 5'd9, 1'b1);
    #1;
    check("mul_wreg", {63'd0, bus.wreg_o}, 64'd0);
    check("mul_wdata", {32'd0, bus.wdata_o}, 64'd0);
    n = bus.stall_req_o ? 1 : 0;
    while (n > 0 && n < 100) begin
      step();
      drive(OP_NOP, SEL_NOP, 32'h5A5A_1234, 32'hC3C3_0F0F, 5'd0, 1'b0);
      #1;
      if (bus.stall_req_o) n++;
      else break;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(OP_OR, SEL_LOGIC, 32'hFFFF_0000, 32'h0000_FFFF, 5'd7, 1'b1);
    #2;
    check("rst_wdata", {32'd0, bus.wdata_o}, 64'd0);
    check("rst_wd", {59'd0, bus.wd_o}, 64'd0);
    check("rst_wreg", {63'd0, bus.wreg_o}, 64'd0);
    drive(OP_MULTU, SEL_NOP, 32'd3, 32'd3, 5'd0, 1'b0);
    #1;
    check("rst_stall", {63'd0, bus.stall_req_o}, 64'd0);
    step();
    step();
    rst = 1'b0;
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1;
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

    drive(OP_ORI, SEL_LOGIC, 32'h0000_1234, 32'h0000_F0F0, 5'd5, 1'b1);
    #1;
    check("ori_wdata", {32'd0, bus.wdata_o}, 64'h0000_F2F4);
    check("ori_wd", {59'd0, bus.wd_o}, 64'd5);
    check("ori_wreg", {63'd0, bus.wreg_o}, 64'd1);

    drive(OP_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd3, 1'b1);
    #1 check("and", {32'd0, bus.wdata_o}, 64'h0F00_0F00);
    drive(OP_XOR, SEL_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd3, 1'b1);
    #1 check("xor", {32'd0, bus.wdata_o}, 64'hF0F0_0F0F);
    drive(OP_NOR, SEL_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd3, 1'b1);
    #1 check("nor", {32'd0, bus.wdata_o}, 64'hFF00_0000);

    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    #1 check("sra", {32'd0, bus.wdata_o}, 64'hF800_0001);
    drive(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    #1 check("srl", {32'd0, bus.wdata_o}, 64'h0800_0001);
    drive(OP_SLL, SEL_SHIFT, 32'd0, 32'hA5A5_5A5A, 5'd4, 1'b1);
    #1 check("sll0", {32'd0, bus.wdata_o}, 64'hA5A5_5A5A);
    drive(OP_SLLV, SEL_SHIFT, 32'hFFFF_FF08, 32'h00FF_00FF, 5'd4, 1'b1);
    #1 check("sllv", {32'd0, bus.wdata_o}, 64'hFF00_FF00);
    drive(OP_SRA, SEL_SHIFT, 32'd0, 32'h8000_0010, 5'd4, 1'b1);
    #1 check("sra0", {32'd0, bus.wdata_o}, 64'h8000_0010);

    drive(OP_MOVN, SEL_MOVE, 32'h1234_5678, 32'd1, 5'd8, 1'b1);
    #1;
    check("movn", {32'd0, bus.wdata_o}, 64'h1234_5678);
    check("movn_wreg", {63'd0, bus.wreg_o}, 64'd1);

    drive(8'hFF, SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);
    #1;
    check("unk_wdata", {32'd0, bus.wdata_o}, 64'd0);
    check("unk_wreg", {63'd0, bus.wreg_o}, 64'd0);
    drive(OP_OR, SEL_NOP, 32'hFFFF_FFFF, 32'd0, 5'd8, 1'b1);
    #1 check("selnop", {31'd0, bus.wreg_o, bus.wdata_o}, 64'd0);

    drive(OP_MTHI, SEL_NOP, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
    #1 check("mthi_wreg", {63'd0, bus.wreg_o}, 64'd0);
    step();
    drive(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    #1;
    check("mfhi", {32'd0, bus.wdata_o}, 64'hDEAD_BEEF);
    check("mfhi_wreg", {63'd0, bus.wreg_o}, 64'd1);
    check("mthi_hilo", {bus.hi_o, bus.lo_o}, 64'hDEAD_BEEF_0000_0000);
    drive(OP_MTLO, SEL_NOP, 32'h0BAD_F00D, 32'd0, 5'd0, 1'b0);
    step();
    drive(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
    #1;
    check("mflo", {32'd0, bus.wdata_o}, 64'h0BAD_F00D);
    check("mtlo_hi", {32'd0, bus.hi_o}, 64'hDEAD_BEEF);

    step();
    run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n_stall);
    check("multu_max_stall", 64'(n_stall), 64'd33);
    check("multu_done_hilo", {bus.hi_o, bus.lo_o}, 64'hDEAD_BEEF_0BAD_F00D);
    step();
    check("multu_max", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);

    drive(OP_MULTU, SEL_NOP, 32'd7, 32'd6, 5'd0, 1'b0);
    step();
    drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (9) step();
    #1 check("busy10_stall", {63'd0, bus.stall_req_o}, 64'd1);
    rst = 1'b1;
    #1 check("rst_mid_stall", {63'd0, bus.stall_req_o}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_stall", {63'd0, bus.stall_req_o}, 64'd0);
    check("post_rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    step();
    check("idle_hold_hilo", {bus.hi_o, bus.lo_o}, 64'd0);

    run_mul(OP_MULTU, 32'd7, 32'd6, n_stall);
    check("multu_7x6_stall", 64'(n_stall), 64'd33);
    step();
    check("multu_7x6", {bus.hi_o, bus.lo_o}, 64'd42);

    run_mul(OP_MULTU, 32'h0001_0000, 32'h0001_0000, n_stall);
    check("b2b_stall", 64'(n_stall), 64'd33);
    step();
    check("b2b_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0000);

    run_mul(OP_MULT, 32'hFFFF_FFFD, 32'd5, n_stall);
`ifdef EX_SIGNED_MUL_EN
    check("mult_stall", 64'(n_stall), 64'd33);
    step();
    check("mult_neg", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, n_stall);
    check("mult_min_stall", 64'(n_stall), 64'd33);
    step();
    check("mult_min", {bus.hi_o, bus.lo_o}, 64'h4000_0000_0000_0000);
`else
    check("mult_nostall", 64'(n_stall), 64'd0);
    step();
    check("mult_nop_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0000);
    #1 check("mult_nop_stall", {63'd0, bus.stall_req_o}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
